// File: rtl/sram32_master_pkg.sv
// Shared encodings for the sram32_master block.
// Holds the request size codes and the 2-bit FSM state type used by the
// controller and its lane-alignment helper.
package sram32_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_RSVD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/sram32_master_if.sv
// Bundle of the core-side request/response channels and the SRAM port.
//   req_*  : core request (valid/ready), byte address, right-aligned wdata
//   rsp_*  : response (valid/ready), extended read data, error flag
//   sram_* : single-cycle strobes, lane enables, word address, wdata/rdata
// modport master : the controller's view
// modport slave  : the core + SRAM environment's view
interface sram32_master_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_signed;
  logic [ADDR_WIDTH+1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic                  sram_rd;
  logic                  sram_we;
  logic [3:0]            sram_byte_en;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [31:0]           sram_wdata;
  logic [31:0]           sram_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  rsp_ready, sram_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output sram_rd, sram_we, sram_byte_en, sram_addr, sram_wdata
  );

  modport slave (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output rsp_ready, sram_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  sram_rd, sram_we, sram_byte_en, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram32_lane_align.sv
// Combinational lane steering for the 32-bit SRAM port.
//   i_size, i_addr_lo : access size and low byte-address bits
//   i_signed          : sign-extend byte/half read data
//   i_wdata           : right-aligned write data
//   i_rdata           : raw SRAM word
//   o_byte_en         : lane enables
//   o_wdata           : lane-replicated write data
//   o_rdata           : selected lane shifted to bit 0 and extended
//   o_misalign        : access error (only with SRAM32_MASTER_ALIGN_CHK_EN)
// Without SRAM32_MASTER_ALIGN_CHK_EN the reserved size behaves as a word and
// misaligned low address bits are simply ignored.
module sram32_lane_align
  import sram32_master_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_byte_en,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    o_rdata   = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      SZ_HALF: begin
        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = {{16{i_signed & w_half[15]}}, w_half};
      end
      default: ;  // word (and reserved size treated as word)
    endcase
  end

`ifdef SRAM32_MASTER_ALIGN_CHK_EN
  assign o_misalign = (i_size == SZ_RSVD) ||
                      ((i_size == SZ_HALF) && i_addr_lo[0]) ||
                      ((i_size == SZ_WORD) && (i_addr_lo != 2'b00));
`else
  assign o_misalign = 1'b0;
`endif

endmodule

// File: rtl/sram32_master.sv
// Initiator-side controller for a 32-bit byte-enabled synchronous SRAM.
// One request at a time walks IDLE -> ACCESS -> WAIT -> RESP -> IDLE; every
// output is a register.
//   i_clk   : clock, rising edge
//   i_rst_n : synchronous active-low reset
//   bus     : sram32_master_if.master (request, response and SRAM port)
// Optional macro SRAM32_MASTER_ALIGN_CHK_EN: misaligned / reserved-size
// requests suppress both strobes and respond with rsp_err=1, rsp_rdata=0.
module sram32_master
  import sram32_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 11
) (
  input logic             i_clk,
  input logic             i_rst_n,
  sram32_master_if.master bus
);

  state_t                r_state, w_state;
  logic                  r_req_ready, w_req_ready;
  logic                  r_rsp_valid, w_rsp_valid;
  logic [31:0]           r_rsp_rdata, w_rsp_rdata;
  logic                  r_rsp_err, w_rsp_err;
  logic                  r_sram_rd, w_sram_rd;
  logic                  r_sram_we, w_sram_we;
  logic [3:0]            r_byte_en, w_byte_en;
  logic [ADDR_WIDTH-1:0] r_sram_addr, w_sram_addr;
  logic [31:0]           r_sram_wdata, w_sram_wdata;

  // latched request attributes needed for the response
  logic                  r_we, w_we;
  logic [1:0]            r_size, w_size;
  logic                  r_signed, w_signed;
  logic [1:0]            r_alo, w_alo;
  logic                  r_err, w_err;

  // Single aligner instance: in IDLE it looks at the incoming request to
  // build the SRAM outputs, afterwards at the latched request to extract
  // the read lane.
  logic                  w_idle;
  logic [1:0]            w_la_size, w_la_alo;
  logic                  w_la_signed, w_la_mis;
  logic [3:0]            w_la_be;
  logic [31:0]           w_la_wdata, w_la_rdata;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_la_size   = w_idle ? bus.req_size      : r_size;
  assign w_la_alo    = w_idle ? bus.req_addr[1:0] : r_alo;
  assign w_la_signed = w_idle ? bus.req_signed    : r_signed;

  sram32_lane_align u_align (
    .i_size     (w_la_size),
    .i_addr_lo  (w_la_alo),
    .i_signed   (w_la_signed),
    .i_wdata    (bus.req_wdata),
    .i_rdata    (bus.sram_rdata),
    .o_byte_en  (w_la_be),
    .o_wdata    (w_la_wdata),
    .o_rdata    (w_la_rdata),
    .o_misalign (w_la_mis)
  );

  always_comb begin
    w_state      = r_state;
    w_req_ready  = r_req_ready;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_rdata  = r_rsp_rdata;
    w_rsp_err    = r_rsp_err;
    w_sram_rd    = 1'b0;
    w_sram_we    = 1'b0;
    w_byte_en    = r_byte_en;
    w_sram_addr  = r_sram_addr;
    w_sram_wdata = r_sram_wdata;
    w_we         = r_we;
    w_size       = r_size;
    w_signed     = r_signed;
    w_alo        = r_alo;
    w_err        = r_err;
    case (r_state)
      ST_IDLE: begin
        // req_ready comes up one edge after reset release
        w_req_ready = 1'b1;
        if (bus.req_valid && r_req_ready) begin
          w_we         = bus.req_we;
          w_size       = bus.req_size;
          w_signed     = bus.req_signed;
          w_alo        = bus.req_addr[1:0];
          w_err        = w_la_mis;
          w_byte_en    = w_la_be;
          w_sram_addr  = bus.req_addr[ADDR_WIDTH+1:2];
          w_sram_wdata = w_la_wdata;
          w_sram_rd    = !bus.req_we && !w_la_mis;
          w_sram_we    =  bus.req_we && !w_la_mis;
          w_req_ready  = 1'b0;
          w_state      = ST_ACCESS;
        end
      end
      ST_ACCESS: w_state = ST_WAIT;
      ST_WAIT: begin
        // SRAM read data is valid during this cycle
        w_rsp_valid = 1'b1;
        w_rsp_rdata = (r_we || r_err) ? 32'h0 : w_la_rdata;
        w_rsp_err   = r_err;
        w_state     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          w_rsp_valid = 1'b0;
          w_req_ready = 1'b1;
          w_state     = ST_IDLE;
        end
      end
      default: w_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_req_ready  <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= 1'b0;
      r_sram_rd    <= 1'b0;
      r_sram_we    <= 1'b0;
      r_byte_en    <= '0;
      r_sram_addr  <= '0;
      r_sram_wdata <= '0;
      r_we         <= 1'b0;
      r_size       <= SZ_BYTE;
      r_signed     <= 1'b0;
      r_alo        <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_req_ready  <= w_req_ready;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_rdata  <= w_rsp_rdata;
      r_rsp_err    <= w_rsp_err;
      r_sram_rd    <= w_sram_rd;
      r_sram_we    <= w_sram_we;
      r_byte_en    <= w_byte_en;
      r_sram_addr  <= w_sram_addr;
      r_sram_wdata <= w_sram_wdata;
      r_we         <= w_we;
      r_size       <= w_size;
      r_signed     <= w_signed;
      r_alo        <= w_alo;
      r_err        <= w_err;
    end
  end

  assign bus.req_ready    = r_req_ready;
  assign bus.rsp_valid    = r_rsp_valid;
  assign bus.rsp_rdata    = r_rsp_rdata;
  assign bus.rsp_err      = r_rsp_err;
  assign bus.sram_rd      = r_sram_rd;
  assign bus.sram_we      = r_sram_we;
  assign bus.sram_byte_en = r_byte_en;
  assign bus.sram_addr    = r_sram_addr;
  assign bus.sram_wdata   = r_sram_wdata;

endmodule

// File: tb/tb_sram32_master.sv
// Self-checking bench for sram32_master: behavioural SRAM, a word-array
// reference memory, directed cases with literal expectations and a
// randomized request stream. Honors SRAM32_MASTER_ALIGN_CHK_EN.
module tb_sram32_master;
  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_mem = 1'b1;
  always #5 clk = ~clk;

  sram32_master_if #(.ADDR_WIDTH(AW)) bus();
  sram32_master #(.ADDR_WIDTH(AW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

  logic [31:0] mem  [0:2047];
  logic [31:0] gold [0:2047];
  int checks = 0, failures = 0, n_strobe = 0, n_both = 0;
  logic [31:0] last_rsp, last_wd;
  logic [3:0]  last_be;
  logic [10:0] last_addr;

  // SRAM: registered read, per-lane write, no reset
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 2048; i++) mem[i] <= gold[i];
    end else begin
      if (bus.sram_we)
        for (int i = 0; i < 4; i++)
          if (bus.sram_byte_en[i]) mem[bus.sram_addr][8*i +: 8] <= bus.sram_wdata[8*i +: 8];
      if (bus.sram_rd) bus.sram_rdata <= mem[bus.sram_addr];
    end
  end

  always @(negedge clk) begin
    if (bus.sram_rd | bus.sram_we) n_strobe <= n_strobe + 1;
    if (bus.sram_rd & bus.sram_we) n_both <= n_both + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [1:0] sz, input logic [12:0] a);
    bit r;
    r = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`ifndef SRAM32_MASTER_ALIGN_CHK_EN
    r = 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [12:0] a);
    if (sz == 2'd0) return 4'b0001 << a[1:0];
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_rep(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return {24'h0, wd[7:0]} * 32'h01010101;
    if (sz == 2'd1) return {16'h0, wd[15:0]} * 32'h00010001;
    return wd;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] sz, input bit sg,
                                         input logic [12:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (sg && v[7]) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (sg && v[15]) v = v | 32'hFFFF0000;
    end else v = w;
    return v;
  endfunction

  // One full transaction; hold = cycles rsp_ready stays low in RESP;
  // early = raise req_valid before the handshake edge (must not be taken).
  task automatic txn(input bit we, input logic [1:0] sz, input bit sg, input logic [12:0] a,
                     input logic [31:0] wd, input int hold, input bit early);
    logic [31:0] exp_rd, rep;
    logic [3:0]  be;
    bit mis;
    int n0, k;
    k = 0;
    @(negedge clk);
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (!bus.req_ready) begin chk("ready_timeout", {31'h0, bus.req_ready}, 32'h1); return; end
    bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd; bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    mis = m_mis(sz, a); be = m_be(sz, a); rep = m_rep(sz, wd);
    exp_rd = (we || mis) ? 32'h0 : m_read(sz, sg, a, gold[a[12:2]]);
    if (we && !mis)
      for (int i = 0; i < 4; i++) if (be[i]) gold[a[12:2]][8*i +: 8] = rep[8*i +: 8];
    n0 = n_strobe;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("acc_rd", {31'h0, bus.sram_rd}, {31'h0, !we && !mis});
    chk("acc_we", {31'h0, bus.sram_we}, {31'h0, we && !mis});
    chk("acc_addr", {21'h0, bus.sram_addr}, {21'h0, a[12:2]});
    chk("acc_be", {28'h0, bus.sram_byte_en}, {28'h0, be});
    if (we) chk("acc_wdata", bus.sram_wdata, rep);
    chk("acc_rdy", {31'h0, bus.req_ready}, 32'h0);
    last_be = bus.sram_byte_en; last_wd = bus.sram_wdata; last_addr = bus.sram_addr;
    @(posedge clk); #1;
    chk("wait_strobe", {31'h0, bus.sram_rd | bus.sram_we}, 32'h0);
    chk("wait_rspv", {31'h0, bus.rsp_valid}, 32'h0);
    @(posedge clk); #1;
    chk("rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, mis});
    last_rsp = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("hold_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_rdy", {31'h0, bus.req_ready | bus.sram_rd | bus.sram_we}, 32'h0);
    end
    bus.rsp_ready = 1'b1;
    if (early) bus.req_valid = 1'b1;
    @(posedge clk); #1;
    chk("hs_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("hs_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("hs_no_strobe", {31'h0, bus.sram_rd | bus.sram_we}, 32'h0);
    chk("strobe_count", n_strobe - n0, mis ? 0 : 1);
  endtask

  initial begin
    int bad;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < 2048; i++) gold[i] = $urandom;

    // reset: all outputs zero, req_ready one edge after release
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_zero", {31'h0, |{bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err,
                                bus.sram_rd, bus.sram_we, bus.sram_byte_en, bus.sram_addr,
                                bus.sram_wdata}}, 32'h0);
    end
    load_mem = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("rdy_before_edge", {31'h0, bus.req_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rdy_after_release", {31'h0, bus.req_ready}, 32'h1);

    // directed cases with literal pins
    txn(1, 2'd2, 0, 13'h10, 32'hDEADBEEF, 0, 0);
    chk("pin_word_be", {28'h0, last_be}, 32'hF);
    chk("pin_word_addr", {21'h0, last_addr}, 32'h4);
    txn(0, 2'd2, 0, 13'h10, 32'h0, 0, 0);
    chk("pin_word_rd", last_rsp, 32'hDEADBEEF);
    txn(1, 2'd0, 0, 13'h13, 32'h00000080, 0, 0);
    chk("pin_byte_be", {28'h0, last_be}, 32'h8);
    chk("pin_byte_wd", last_wd, 32'h80808080);
    txn(0, 2'd0, 1, 13'h13, 32'h0, 0, 0);
    chk("pin_sbyte_rd", last_rsp, 32'hFFFFFF80);
    txn(0, 2'd0, 0, 13'h13, 32'h0, 0, 1);
    chk("pin_ubyte_rd", last_rsp, 32'h00000080);
    txn(0, 2'd1, 1, 13'h12, 32'h0, 5, 0);
    chk("pin_shalf_rd", last_rsp, 32'hFFFF80AD);
    txn(1, 2'd2, 0, 13'h11, 32'h12345678, 0, 0);
    txn(0, 2'd2, 0, 13'h10, 32'h0, 0, 0);
`ifdef SRAM32_MASTER_ALIGN_CHK_EN
    chk("pin_misalign_mem", mem[4], 32'h80ADBEEF);
`else
    chk("pin_misalign_mem", mem[4], 32'h12345678);
`endif
    chk("pin_misalign_rd", last_rsp, mem[4]);

    // reset on the edge that ends a write's ACCESS cycle
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 13'h40; bus.req_wdata = 32'hCAFEF00D; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rm_strobe", {31'h0, bus.sram_we}, 32'h1);
    rst_n = 1'b0;
    gold[16] = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rm_zero", {31'h0, |{bus.req_ready, bus.rsp_valid, bus.sram_we, bus.sram_rd,
                              bus.sram_addr, bus.sram_byte_en}}, 32'h0);
    chk("rm_committed", mem[16], 32'hCAFEF00D);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rm_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("rm_no_rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end
    txn(0, 2'd2, 0, 13'h40, 32'h0, 0, 0);
    chk("rm_readback", last_rsp, 32'hCAFEF00D);

    // randomized stream over a small window to get read-after-write hits
    for (int t = 0; t < 120; t++)
      txn($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
          13'($urandom_range(0, 63)), $urandom, $urandom_range(0, 2),
          (t < 119) && ($urandom_range(0, 3) == 0));
    bus.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    bad = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== gold[i]) bad++;
    chk("mem_final", bad, 0);
    chk("both_strobes", n_both, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
